// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: bundles the core-side request/response signals and the
// word-wide memory request signals of the memory controller.
// The slave modport is the controller; the master modport is its
// environment (core plus memory).
interface mem_ctrl_if #(
  parameter int IADDR_W = 16
);
  // Core side
  logic [IADDR_W-1:0] cpu_addr;
  logic [15:0]        cpu_wdata;
  logic               cpu_read;
  logic               cpu_write;
  logic               cpu_instr_access;
  logic               cpu_read_done;
  logic [15:0]        cpu_rdata;
  logic [31:0]        cpu_instr;
  logic               cpu_busy;
  logic               cpu_cack;
  logic               cpu_ready;
  // Memory side
  logic [IADDR_W:0]   mem_addr;
  logic [15:0]        mem_wdata;
  logic               mem_req;
  logic               mem_we;
  logic               mem_ack;
  logic [15:0]        mem_rdata;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_read, cpu_write, cpu_instr_access,
           cpu_read_done, mem_ack, mem_rdata,
    output cpu_rdata, cpu_instr, cpu_busy, cpu_cack, cpu_ready,
           mem_addr, mem_wdata, mem_req, mem_we
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_read, cpu_write, cpu_instr_access,
           cpu_read_done, mem_ack, mem_rdata,
    input  cpu_rdata, cpu_instr, cpu_busy, cpu_cack, cpu_ready,
           mem_addr, mem_wdata, mem_req, mem_we
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: turns the core's level-held read / write / instruction-fetch
// requests into single-word memory transactions. Instructions are built
// from two consecutive 16-bit words (low word first).
// Optional feature: define MEM_CTRL_IBUF_EN to add a one-entry
// instruction buffer (tag + valid) that answers a repeated fetch of the
// last fetched address without touching memory.
module mem_ctrl #(
  parameter int IADDR_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_ILO,
    S_IHI,
    S_DONE
  } state_t;

  state_t             state;
  state_t             next_state;
  logic               accept;      // request taken in IDLE this cycle
  logic               ibuf_hit;    // accepted fetch served by the buffer
  logic               ibuf_match;  // buffer holds the requested address
  logic [IADDR_W-1:0] addr_q;      // latched request address
  logic [IADDR_W-1:0] ilo_addr;    // low instruction word, from the request
  logic [IADDR_W-1:0] ihi_addr;    // high instruction word, from the latch

  // Word addresses of an instruction: shift left drops the MSB, and the
  // +1 of the high word only ever sets bit 0, so it wraps modulo 2^IADDR_W.
  assign ilo_addr = {bus.cpu_addr[IADDR_W-2:0], 1'b0};
  assign ihi_addr = {addr_q[IADDR_W-2:0], 1'b1};

  // The memory request is the only combinational output: it follows state.
  assign bus.mem_req = (state == S_RD) || (state == S_WR) ||
                       (state == S_ILO) || (state == S_IHI);

`ifdef MEM_CTRL_IBUF_EN
  logic               ibuf_valid;
  logic [IADDR_W-1:0] ibuf_tag;

  assign ibuf_match = ibuf_valid && (ibuf_tag == bus.cpu_addr);

  // Instruction buffer: loaded by a completed fetch, invalidated by any
  // accepted instruction-space write.
  always_ff @(posedge clk) begin
    if (rst) begin
      ibuf_valid <= 1'b0;
      ibuf_tag   <= '0;
    end else begin
      if (state == S_IHI && bus.mem_ack) begin
        ibuf_valid <= 1'b1;
        ibuf_tag   <= addr_q;
      end
      if (accept && bus.cpu_write && bus.cpu_instr_access) begin
        ibuf_valid <= 1'b0;
      end
    end
  end
`else
  assign ibuf_match = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values; the combinational block
    // below uses blocking assignments because it is evaluated in order.
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and acceptance strobes.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    next_state = state;
    accept     = 1'b0;
    ibuf_hit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.cpu_write) begin
          next_state = S_WR;
          accept     = 1'b1;
        end else if (bus.cpu_read && bus.cpu_instr_access) begin
          accept = 1'b1;
          if (ibuf_match) begin
            next_state = S_DONE;
            ibuf_hit   = 1'b1;
          end else begin
            next_state = S_ILO;
          end
        end else if (bus.cpu_read) begin
          next_state = S_RD;
          accept     = 1'b1;
        end
      end
      S_RD, S_WR, S_IHI: begin
        if (bus.mem_ack) next_state = S_DONE;
      end
      S_ILO: begin
        if (bus.mem_ack) next_state = S_IHI;
      end
      S_DONE: begin
        // A buffer hit spends its first DONE cycle with ready still low,
        // so exit is only considered once ready is visible to the core.
        if (bus.cpu_ready &&
            (bus.cpu_read_done || (!bus.cpu_read && !bus.cpu_write))) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Registered core-side handshake, memory address/data and read results.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.cpu_rdata <= '0;
      bus.cpu_instr <= '0;
      bus.cpu_busy  <= 1'b0;
      bus.cpu_cack  <= 1'b0;
      bus.cpu_ready <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_we    <= 1'b0;
      addr_q        <= '0;
    end else begin
      bus.cpu_cack  <= accept;
      bus.cpu_busy  <= (next_state == S_RD) || (next_state == S_WR) ||
                       (next_state == S_ILO) || (next_state == S_IHI) ||
                       ibuf_hit;
      bus.cpu_ready <= (next_state == S_DONE) && !ibuf_hit;
      bus.mem_we    <= (next_state == S_WR);

      if (accept) begin
        addr_q        <= bus.cpu_addr;
        bus.mem_wdata <= bus.cpu_wdata;
        if (bus.cpu_write) begin
          bus.mem_addr <= {bus.cpu_instr_access, bus.cpu_addr};
        end else if (bus.cpu_instr_access) begin
          bus.mem_addr <= {1'b1, ilo_addr};
        end else begin
          bus.mem_addr <= {1'b0, bus.cpu_addr};
        end
      end

      if (bus.mem_ack) begin
        case (state)
          S_RD:  bus.cpu_rdata <= bus.mem_rdata;
          S_ILO: begin
            bus.cpu_instr[15:0] <= bus.mem_rdata;
            bus.mem_addr        <= {1'b1, ihi_addr};
          end
          S_IHI: bus.cpu_instr[31:16] <= bus.mem_rdata;
          default: ;
        endcase
      end
    end
  end

endmodule
